// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter block.
// Holds the operand and shift-amount widths and the 2-bit operation
// encoding that both the combinational core and the testbench use.
package shifter_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    // Operation select. MODE_PASS is a reserved code that forwards the
    // operand untouched, so it never lets X reach the output.
    typedef enum logic [1:0] {
        MODE_SLL  = 2'b00,
        MODE_SRA  = 2'b01,
        MODE_ROR  = 2'b10,
        MODE_PASS = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shifter_if.sv
// Operand/result bundle for the shifter.
// Signals:
//   Shift_In  [15:0]  operand to shift
//   Shift_Val [3:0]   shift amount, 0-15, unsigned
//   Mode      [1:0]   operation select (see shifter_pkg::shift_mode_e)
//   Shift_Out [15:0]  registered result
// Modports:
//   master  drives the operand side and observes the result
//   slave   the shifter itself
interface shifter_if;

    logic [shifter_pkg::WIDTH-1:0]   Shift_In;
    logic [shifter_pkg::SHAMT_W-1:0] Shift_Val;
    logic [1:0]                      Mode;
    logic [shifter_pkg::WIDTH-1:0]   Shift_Out;

    modport master (
        output Shift_In,
        output Shift_Val,
        output Mode,
        input  Shift_Out
    );

    modport slave (
        input  Shift_In,
        input  Shift_Val,
        input  Mode,
        output Shift_Out
    );

endinterface

// File: rtl/shifter_core.sv
// Purely combinational 16-bit logarithmic barrel shifter.
// Ports:
//   data   [15:0]  operand
//   amount [3:0]   shift amount, 0-15
//   mode   [1:0]   SLL / SRA / ROR / pass-through
//   result [15:0]  shifted operand
module shifter_core
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] stage_val;
    logic [WIDTH-1:0] shifted;
    int unsigned      step;

    // Four stages shifting by 1, 2, 4 and 8; stage k is enabled by
    // amount[k]. The fill differs per mode: zeros for SLL, copies of the
    // sign bit for SRA, and the bits falling off the LSB for ROR. The
    // pass-through code keeps every stage transparent regardless of amount.
    always_comb begin
        stage_val = data;
        shifted   = data;
        step      = 0;
        for (int k = 0; k < SHAMT_W; k++) begin
            step    = 32'd1 << k;
            shifted = stage_val;
            case (shift_mode_e'(mode))
                MODE_SLL: shifted = stage_val << step;
                MODE_SRA: shifted = $unsigned($signed(stage_val) >>> step);
                MODE_ROR: shifted = (stage_val >> step) | (stage_val << (WIDTH - step));
                default:  shifted = stage_val;
            endcase
            if (amount[k]) begin
                stage_val = shifted;
            end
        end
        result = stage_val;
    end

endmodule

// File: rtl/shifter.sv
// Three-function 16-bit barrel shifter with a registered result.
// One clock of latency; a new operation is accepted every cycle.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset, clears the result
//   bus  shifter_if slave: Shift_In, Shift_Val, Mode in; Shift_Out out
module shifter
    import shifter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    shifter_if.slave  bus
);

    logic [WIDTH-1:0] core_result;

    shifter_core u_core (
        .data   (bus.Shift_In),
        .amount (bus.Shift_Val),
        .mode   (bus.Mode),
        .result (core_result)
    );

    // Single output register; reset takes priority over any operation
    // presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Shift_Out <= '0;
        end else begin
            bus.Shift_Out <= core_result;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for the shifter. A driver applies one operation per
// cycle and queues the expected result; an independent monitor pops and
// compares one result per rising edge.
module tb_shifter;

    logic clk;
    logic rst;

    typedef struct {
        logic [15:0] expected;
        string       name;
    } exp_item_t;

    exp_item_t exp_q[$];
    int        checks;
    int        errors;

    shifter_if sif ();

    shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the operation definitions with plain
    // 32-bit integer arithmetic.
    function automatic logic [15:0] refShift(input logic [15:0] v, input int amt,
                                             input logic [1:0] m, input logic r);
        int unsigned u;
        int          sv;
        if (r) return 16'h0000;
        u  = 32'(v);
        sv = int'($signed(v));
        case (m)
            2'b00:   return 16'((u << amt) & 32'hFFFF);
            2'b01:   return 16'(sv >>> amt);
            2'b10:   return 16'(((u >> amt) | (u << (16 - amt))) & 32'hFFFF);
            default: return v;
        endcase
    endfunction

    // Drive one operation at the falling edge and queue what should appear
    // after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [15:0] v, input int amt,
                                 input logic [1:0] m, input logic [15:0] expected,
                                 input string name);
        exp_item_t item;
        @(negedge clk);
        rst           = r;
        sif.Shift_In  = v;
        sif.Shift_Val = amt[3:0];
        sif.Mode      = m;
        item.expected = expected;
        item.name     = name;
        exp_q.push_back(item);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: one result per rising edge, sampled just after the edge.
    initial begin
        exp_item_t item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                checkOutput(item.name, sif.Shift_Out, item.expected);
            end
        end
    end

    initial begin
        logic [15:0] v;
        int          amt;
        logic [1:0]  m;
        logic        r;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        sif.Shift_In  = 16'h0000;
        sif.Shift_Val = 4'd0;
        sif.Mode      = 2'b00;

        // Reset held for two edges with a nonzero operand present.
        applyStimulus(1'b1, 16'hFFFF, 0, 2'b00, 16'h0000, "reset0");
        applyStimulus(1'b1, 16'hFFFF, 0, 2'b00, 16'h0000, "reset1");

        // Directed cases, back to back, one per cycle.
        applyStimulus(1'b0, 16'h1824,  4, 2'b00, 16'h8240, "sll_4");
        applyStimulus(1'b0, 16'h1824,  0, 2'b00, 16'h1824, "sll_0");
        applyStimulus(1'b0, 16'h0001, 15, 2'b00, 16'h8000, "sll_15");
        applyStimulus(1'b0, 16'h8000, 15, 2'b01, 16'hFFFF, "sra_neg_15");
        applyStimulus(1'b0, 16'h7FFF,  3, 2'b01, 16'h0FFF, "sra_pos_3");
        applyStimulus(1'b0, 16'hF0F0,  4, 2'b01, 16'hFF0F, "sra_f0f0_4");
        applyStimulus(1'b0, 16'h7FFF, 15, 2'b01, 16'h0000, "sra_pos_15");
        applyStimulus(1'b0, 16'h9ABC,  0, 2'b01, 16'h9ABC, "sra_0");
        applyStimulus(1'b0, 16'h1824,  1, 2'b10, 16'h0C12, "ror_1");
        applyStimulus(1'b0, 16'h1824,  4, 2'b10, 16'h4182, "ror_4");
        applyStimulus(1'b0, 16'h1824,  8, 2'b10, 16'h2418, "ror_8");
        applyStimulus(1'b0, 16'h1824, 15, 2'b10, 16'h3048, "ror_15");
        applyStimulus(1'b0, 16'hA5A5,  7, 2'b11, 16'hA5A5, "pass_7");
        applyStimulus(1'b0, 16'h5A5A,  0, 2'b10, 16'h5A5A, "ror_0");

        // Reset mid-stream, then the first result one edge after release.
        applyStimulus(1'b1, 16'h1234,  3, 2'b00, 16'h0000, "reset_mid");
        applyStimulus(1'b0, 16'h1234,  3, 2'b00, 16'h91A0, "after_reset");

        // Rotate sweep over all amounts.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 16'h1824, a, 2'b10, refShift(16'h1824, a, 2'b10, 1'b0),
                          $sformatf("ror_sweep_%0d", a));
        end

        // Randomised traffic, with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            v   = 16'($urandom);
            amt = int'($urandom_range(15, 0));
            m   = 2'($urandom_range(3, 0));
            r   = ($urandom_range(49, 0) == 0);
            applyStimulus(r, v, amt, m, refShift(v, amt, m, r),
                          $sformatf("rand_%0d m=%0d v=%h s=%0d r=%0b", i, m, v, amt, r));
        end

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
